// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter: one byte out on MOSI (MSB first), one byte in from MISO.
// Optional macro SPI_MISO_LATE_SAMPLE_EN moves the MISO sample to the falling-SCK edge.
module spi_byte_engine #(
   parameter int CLK_DIV = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_tx,
   output logic [7:0] data_rx,
   input  logic       txn_start,
   output logic       txn_done,
   output logic       spi_sck,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

   localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

   state_t     state, state_nxt;
   logic       armed;
   logic [2:0] bit_cnt;
   logic [7:0] div_cnt;
   logic [7:0] tx_shift;
   logic [7:0] rx_shift;
   logic       div_tc, accept, lo_tc, hi_tc, last_bit;
   logic [7:0] rx_fin;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = LOW;
         LOW:     if (lo_tc)  state_nxt = HIGH;
         HIGH:    if (hi_tc)  state_nxt = last_bit ? IDLE : LOW;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      div_tc   = (div_cnt == DIV_TC);
      accept   = (state == IDLE) && txn_start && armed;
      lo_tc    = (state == LOW)  && div_tc;
      hi_tc    = (state == HIGH) && div_tc;
      last_bit = (bit_cnt == 3'd7);
`ifdef SPI_MISO_LATE_SAMPLE_EN
      rx_fin   = {rx_shift[6:0], spi_miso};
`else
      rx_fin   = rx_shift;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         txn_done <= 1'b1;
         data_rx  <= 8'h00;
         spi_sck  <= 1'b0;
         spi_mosi <= 1'b0;
         armed    <= 1'b1;
         bit_cnt  <= 3'd0;
         div_cnt  <= 8'd0;
         tx_shift <= 8'h00;
         rx_shift <= 8'h00;
      end else begin
         // a low txn_start on any edge re-arms, busy or not
         if (!txn_start) armed <= 1'b1;
         if (accept) begin
            tx_shift <= data_tx;
            spi_mosi <= data_tx[7];
            txn_done <= 1'b0;
            bit_cnt  <= 3'd0;
            div_cnt  <= 8'd0;
            armed    <= 1'b0;
         end
         if (state != IDLE) div_cnt <= div_tc ? 8'd0 : div_cnt + 8'd1;
         if (lo_tc) begin
            spi_sck  <= 1'b1;
`ifndef SPI_MISO_LATE_SAMPLE_EN
            rx_shift <= {rx_shift[6:0], spi_miso};
`endif
         end
         if (hi_tc) begin
            spi_sck  <= 1'b0;
`ifdef SPI_MISO_LATE_SAMPLE_EN
            rx_shift <= rx_fin;
`endif
            if (last_bit) begin
               data_rx  <= rx_fin;
               txn_done <= 1'b1;
               spi_mosi <= 1'b0;
            end else begin
               tx_shift <= {tx_shift[6:0], 1'b0};
               spi_mosi <= tx_shift[6];
               bit_cnt  <= bit_cnt + 3'd1;
            end
         end
      end
   end

endmodule
